// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_gen
// Description : Hobby-servo PWM generator. Converts an angle command into one
//               pulse per fixed frame, width linear in angle, with the angle
//               and enable sampled only at frame boundaries and a per-frame
//               slew limit on the applied angle.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_gen #(
    parameter int TICK_DIV     = 50,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 500,
    parameter int US_PER_DEG   = 11,
    parameter int STEP_DEG     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] angle,
    input  logic       enable,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [7:0] cur_angle
);

    localparam int          c_DIV_W      = $clog2(TICK_DIV);
    localparam logic [7:0]  c_MAX_ANG    = 8'd180;
    localparam logic [7:0]  c_RST_ANG    = 8'd90;
    localparam logic [7:0]  c_STEP       = 8'(STEP_DEG);
    localparam logic [15:0] c_MIN_PULSE  = 16'(MIN_PULSE_US);
    localparam logic [15:0] c_US_PER_DEG = 16'(US_PER_DEG);
    localparam logic [15:0] c_RST_WIDTH  = 16'(MIN_PULSE_US + 90 * US_PER_DEG);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [15:0]        r_us_cnt;
    logic [7:0]         r_cur_angle;
    logic [15:0]        r_width;
    logic               r_en_lat;
    logic               r_pwm;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_fb;
    logic [7:0]         w_target;
    logic [7:0]         w_diff;
    logic [7:0]         w_slewed;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic [15:0]        w_us_nxt;
    logic [7:0]         w_ang_nxt;
    logic [15:0]        w_width_nxt;
    logic               w_en_nxt;

    assign w_tick   = (r_div_cnt == c_DIV_W'(TICK_DIV - 1));
    assign w_fb     = w_tick && (r_us_cnt == 16'(PERIOD_US - 1));
    assign w_target = (angle > c_MAX_ANG) ? c_MAX_ANG : angle;

    // Move the applied angle toward the clamped target by at most one step.
    always_comb begin
        w_diff   = 8'd0;
        w_slewed = r_cur_angle;
        if (STEP_DEG == 0) begin
            w_slewed = w_target;
        end else if (w_target > r_cur_angle) begin
            w_diff   = w_target - r_cur_angle;
            w_slewed = r_cur_angle + ((w_diff > c_STEP) ? c_STEP : w_diff);
        end else if (w_target < r_cur_angle) begin
            w_diff   = r_cur_angle - w_target;
            w_slewed = r_cur_angle - ((w_diff > c_STEP) ? c_STEP : w_diff);
        end
    end

    // Next-state of the counters and the per-frame latched values.
    always_comb begin
        w_div_nxt   = w_tick ? '0 : r_div_cnt + 1'b1;
        w_us_nxt    = r_us_cnt;
        w_ang_nxt   = r_cur_angle;
        w_width_nxt = r_width;
        w_en_nxt    = r_en_lat;
        if (w_tick) begin
            w_us_nxt = w_fb ? 16'd0 : r_us_cnt + 16'd1;
        end
        if (w_fb) begin
            w_ang_nxt   = w_slewed;
            w_width_nxt = c_MIN_PULSE + 16'(w_slewed) * c_US_PER_DEG;
            w_en_nxt    = enable;
        end
    end

    // State register; pwm is computed from next-state so it rises together
    // with frame_start on the first clk of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_us_cnt      <= 16'd0;
            r_cur_angle   <= c_RST_ANG;
            r_width       <= c_RST_WIDTH;
            r_en_lat      <= 1'b0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_nxt;
            r_us_cnt      <= w_us_nxt;
            r_cur_angle   <= w_ang_nxt;
            r_width       <= w_width_nxt;
            r_en_lat      <= w_en_nxt;
            r_pwm         <= w_en_nxt && (w_us_nxt < w_width_nxt);
            r_frame_start <= w_fb;
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_frame_start;
    assign cur_angle   = r_cur_angle;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_gen
// Description : Self-checking bench for servo_pwm_gen. Two instances share
//               clock and reset: one slew-limited (STEP_DEG=2), one with
//               unlimited slew (STEP_DEG=0). Expected per-frame records are
//               queued by the drivers and checked by a frame monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_gen;

    typedef struct packed {
        logic [7:0] ang;
        int         high;
        int         len;
    } frame_t;

    logic       clk;
    logic       rst;
    logic [7:0] r_angle [2];
    logic       r_en    [2];
    logic       w_pwm   [2];
    logic       w_fs    [2];
    logic [7:0] w_cur   [2];

    frame_t     q0 [$];
    frame_t     q1 [$];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         len_c   [2];
    int         high_c  [2];
    logic [7:0] ang_obs [2];

    servo_pwm_gen #(
        .TICK_DIV(2), .PERIOD_US(3000), .MIN_PULSE_US(500),
        .US_PER_DEG(11), .STEP_DEG(2)
    ) dut_slew (
        .clk(clk), .rst(rst), .angle(r_angle[0]), .enable(r_en[0]),
        .pwm_out(w_pwm[0]), .frame_start(w_fs[0]), .cur_angle(w_cur[0])
    );

    servo_pwm_gen #(
        .TICK_DIV(2), .PERIOD_US(3000), .MIN_PULSE_US(500),
        .US_PER_DEG(11), .STEP_DEG(0)
    ) dut_jump (
        .clk(clk), .rst(rst), .angle(r_angle[1]), .enable(r_en[1]),
        .pwm_out(w_pwm[1]), .frame_start(w_fs[1]), .cur_angle(w_cur[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: angle after one frame boundary.
    function automatic logic [7:0] slew_m(input logic [7:0] cur,
                                          input logic [7:0] raw,
                                          input int step);
        int t;
        int c;
        t = (raw > 8'd180) ? 180 : int'(raw);
        c = int'(cur);
        if (step == 0)   return 8'(t);
        if (t > c)       return 8'(c + ((t - c < step) ? t - c : step));
        if (t < c)       return 8'(c - ((c - t < step) ? c - t : step));
        return cur;
    endfunction

    function automatic frame_t mk(input logic [7:0] ang, input logic en);
        frame_t r;
        r.ang  = ang;
        r.high = en ? (500 + 11 * int'(ang)) * 2 : 0;
        r.len  = 6000;
        return r;
    endfunction

    task automatic push_exp(input int d, input frame_t r);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic wait_fs(input int d);
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (w_fs[d]) return;
        end
        check_eq($sformatf("fs_timeout%0d", d), int'(w_fs[d]), 1);
    endtask

    // Frame monitor: measures each frame and checks it on the next frame_start.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                len_c[d]   <= 0;
                high_c[d]  <= 0;
                ang_obs[d] <= w_cur[d];
            end else if (w_fs[d]) begin
                frame_t rec;
                int     qs;
                qs = (d == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    check_eq($sformatf("unexpected_frame%0d", d), qs, 1);
                end else begin
                    rec = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check_eq($sformatf("angle%0d", d), int'(ang_obs[d]), int'(rec.ang));
                    check_eq($sformatf("high%0d", d), high_c[d], rec.high);
                    check_eq($sformatf("len%0d", d), len_c[d], rec.len);
                end
                len_c[d]   <= 1;
                high_c[d]  <= int'(w_pwm[d]);
                ang_obs[d] <= w_cur[d];
            end else begin
                len_c[d]  <= len_c[d] + 1;
                high_c[d] <= high_c[d] + int'(w_pwm[d]);
            end
        end
    end

    // Drives one instance for frames 1..8; expectation for each frame is
    // derived from the inputs present at the boundary that opens it.
    task automatic run_driver(input int d);
        logic [7:0] m_ang;
        int         step;
        step  = (d == 0) ? 2 : 0;
        m_ang = 8'd90;
        push_exp(d, mk(m_ang, 1'b0));
        for (int f = 2; f <= 8; f++) begin
            m_ang = slew_m(m_ang, r_angle[d], step);
            push_exp(d, mk(m_ang, r_en[d]));
            wait_fs(d);
            if (f == 3) begin
                repeat (1000) @(negedge clk);
                r_angle[d] = (d == 0) ? 8'd100 : 8'd0;
            end
            if (f == 5 && d == 1) begin
                repeat (200) @(negedge clk);
                check_eq("jump_pwm_before_disable", int'(w_pwm[1]), 1);
                r_en[1] = 1'b0;
            end
        end
        wait_fs(d);
    endtask

    initial begin
        rst        = 1'b1;
        r_angle[0] = 8'd90;
        r_en[0]    = 1'b1;
        r_angle[1] = 8'd255;
        r_en[1]    = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_pwm%0d", d), int'(w_pwm[d]), 0);
            check_eq($sformatf("rst_fs%0d", d), int'(w_fs[d]), 0);
            check_eq($sformatf("rst_cur%0d", d), int'(w_cur[d]), 90);
        end
        @(posedge clk);
        #2 rst = 1'b0;

        fork
            run_driver(0);
            run_driver(1);
        join

        // Frame 9 of the slew instance: assert reset in the middle of its pulse.
        repeat (500) @(negedge clk);
        check_eq("pre_rst_pwm", int'(w_pwm[0]), 1);
        check_eq("pre_rst_cur", int'(w_cur[0]), 100);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_pwm", int'(w_pwm[0]), 0);
        check_eq("async_rst_cur0", int'(w_cur[0]), 90);
        check_eq("async_rst_cur1", int'(w_cur[1]), 90);
        repeat (3) @(negedge clk);
        push_exp(0, mk(8'd90, 1'b0));
        push_exp(1, mk(8'd90, 1'b0));
        @(posedge clk);
        #2 rst = 1'b0;
        wait_fs(0);
        @(negedge clk);
        check_eq("q_drain0", q0.size(), 0);
        check_eq("q_drain1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Converts the 8-bit servo angle command (degrees, 90 = centre) into the standard hobby-servo PWM waveform: one pulse per fixed frame, pulse width linear in angle. It sits downstream of the direction-to-angle stage and drives the servo signal pin directly. The angle is sampled only at frame boundaries, so a pulse is never glitched mid-frame. A per-frame slew limit prevents step jumps on the mechanics.

## Interface
Parameters:
- TICK_DIV, 50: clk cycles per 1 µs tick (50 MHz clock); must be ≥ 2.
- PERIOD_US, 20000: frame length in µs (50 Hz).
- MIN_PULSE_US, 500: pulse width at 0°.
- US_PER_DEG, 11: width increment per degree; 180° gives 2480 µs. Requires MIN_PULSE_US + 180·US_PER_DEG < PERIOD_US.
- STEP_DEG, 2: maximum change of the applied angle per frame; 0 = unlimited (jump to target).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- angle  input  8  commanded angle in degrees; values > 180 are clamped to 180.
- enable  input  1  pulse output enable; sampled at frame boundaries.
- pwm_out  output  1  registered servo PWM signal.
- frame_start  output  1  one-clk strobe marking the first clk of each frame.
- cur_angle  output  8  angle applied to the current frame after clamping and slew.

## Operation
- Prescaler div_cnt counts 0..TICK_DIV-1 and wraps. tick = (div_cnt == TICK_DIV-1).
- Frame counter us_cnt (16 bit) increments on tick and wraps PERIOD_US-1 → 0.
- Frame boundary event fb = tick && us_cnt == PERIOD_US-1. On the fb edge:
  - target t = min(angle, 180).
  - If STEP_DEG == 0: cur_angle ← t. Else if t > cur_angle: cur_angle ← cur_angle + min(STEP_DEG, t − cur_angle). If t < cur_angle: cur_angle ← cur_angle − min(STEP_DEG, cur_angle − t). If equal: unchanged.
  - width_us ← MIN_PULSE_US + new cur_angle · US_PER_DEG (16-bit, no overflow under the parameter constraint).
  - en_lat ← enable.
- Every clk: pwm_out ← en_lat && (us_cnt < width_us); frame_start ← fb.
- Changes to angle or enable between boundaries have no effect until the next fb.
- Reset values: div_cnt = 0, us_cnt = 0, cur_angle = 90, width_us = MIN_PULSE_US + 90·US_PER_DEG (1490), en_lat = 0, pwm_out = 0, frame_start = 0.
- Reset is asynchronous at any point, including mid-pulse. pwm_out drops to 0 immediately, and the frame restarts from us_cnt = 0 on release.

## Timing
- Frame length is exactly PERIOD_US·TICK_DIV clks (default 1,000,000).
- frame_start is high during the clk in which us_cnt = 0 and div_cnt = 0, i.e. 1 clk after the fb edge.
- No frame_start is produced for the first frame after reset release.
- pwm_out rises on the same clk that frame_start is high. It stays high exactly width_us·TICK_DIV clks, then stays low for the rest of the frame.
- The first frame after reset always has pwm_out = 0, because en_lat resets to 0. The earliest pulse is in frame 2 when enable = 1.
- Angle-to-output latency: a new angle takes effect at the next frame boundary. Reaching it from cur_angle takes ceil(|Δ| / STEP_DEG) frames.
- Enable deasserted mid-pulse: the pulse completes. The next frame has no pulse.
- Simultaneous angle change and fb: the value present at the fb edge is used.

## Test plan
Simulation parameters for all scenarios: TICK_DIV = 2, PERIOD_US = 3000, defaults otherwise.
- Reset, then enable = 1, angle = 90 held → frame 1 has no pulse. From frame 2 onward, pwm_out is high 2980 clks per 6000-clk frame. cur_angle = 90, and frame_start pulses every 6000 clks.
- angle stepped 90 → 100 mid-frame → the current frame is still 2980 clks. cur_angle then reads 92, 94, 96, 98, 100 over the next 5 frames, with high time 3024, 3068, 3112, 3156, 3200 clks.
- angle = 255 with STEP_DEG = 0 → clamped to 180 at the next boundary. High time is 4960 clks per frame.
- angle = 0 with STEP_DEG = 0 → high time 1000 clks. Then enable = 0 mid-pulse → that pulse completes at 1000 clks, and the following frames have pwm_out = 0.
- rst asserted mid-pulse → pwm_out = 0 and cur_angle = 90 asynchronously. After release, frame timing restarts from us_cnt = 0 and the first frame has no pulse.
